// File: rtl/scc_cfg_seq_if.sv
// rtl/scc_cfg_seq_if.sv - AXI4-lite bus interface (axi4_lite_if) with master/slave modports
interface axi4_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic            awvalid;
  logic            awready;
  logic [AW-1:0]   awaddr;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [AW-1:0]   araddr;
  logic            rvalid;
  logic            rready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;

  modport m (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport s (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/scc_cfg_seq.sv
// rtl/scc_cfg_seq.sv - post-link-up AXI4-lite register table sequencer
// Optional write readback check: define SCC_CFG_VERIFY_EN.
module scc_cfg_seq #(
  parameter int          N_ENTRIES   = 8,
  parameter int          TIMEOUT_CYC = 1024,
  parameter int          POLL_GAP    = 16,
  parameter logic [31:0] SR_ADDR     = 32'h00
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        cdr_locked,
  input  logic        start,
  output logic [7:0]  cfg_idx,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_data,
  axi4_lite_if.m      mmr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_idx
);
  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_LOCK, S_POLL_AR, S_POLL_R, S_POLL_GAP, S_WR, S_WR_B,
`ifdef SCC_CFG_VERIFY_EN
    S_VFY_AR, S_VFY_R,
`endif
    S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d, err_idx_q, err_idx_d;
  logic [31:0] addr_q, addr_d, data_q, data_d, araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        aw_ok_q, aw_ok_d, w_ok_q, w_ok_d, issued_q, issued_d, lost_q, lost_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        tmo, lost, aw_acc, w_acc, tmo_hit, err_hit, entry_ok, restart;

  always_comb begin
    state_d = state_q;   idx_d = idx_q;         err_idx_d = err_idx_q;
    addr_d = addr_q;     data_d = data_q;       araddr_d = araddr_q;
    arvalid_d = arvalid_q; rready_d = rready_q; awvalid_d = awvalid_q;
    wvalid_d = wvalid_q; bready_d = bready_q;   aw_ok_d = aw_ok_q;
    w_ok_d = w_ok_q;     issued_d = issued_q;
    busy_d = busy_q;     done_d = done_q;       error_d = error_q;
    lost_d = lost_q | (busy_q & ~cdr_locked);
    lost = lost_q | ~cdr_locked;
    tmo = (cnt_q == 32'(TIMEOUT_CYC - 1));
    aw_acc = awvalid_q & mmr.awready;
    w_acc = wvalid_q & mmr.wready;
    tmo_hit = 1'b0; err_hit = 1'b0; entry_ok = 1'b0; restart = 1'b0;

    case (state_q)
      S_IDLE: begin
        lost_d = 1'b0;
        if (start) begin
          state_d = S_WAIT_LOCK; idx_d = 8'd0;
          done_d = 1'b0; error_d = 1'b0; busy_d = 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        lost_d = 1'b0;
        if (cdr_locked) begin
          state_d = S_POLL_AR; arvalid_d = 1'b1; rready_d = 1'b1; araddr_d = SR_ADDR;
        end
      end
      S_POLL_AR: begin
        if (mmr.arready) begin
          arvalid_d = 1'b0; state_d = S_POLL_R;
        end else if (tmo) tmo_hit = 1'b1;
      end
      S_POLL_R: begin
        if (mmr.rvalid) begin
          rready_d = 1'b0;
          if (mmr.rresp != 2'b00) err_hit = 1'b1;
          else if (lost) restart = 1'b1;
          else if (mmr.rdata[0]) begin state_d = S_WR; issued_d = 1'b0; end
          else state_d = S_POLL_GAP;
        end else if (tmo) tmo_hit = 1'b1;
      end
      S_POLL_GAP: begin
        if (lost) restart = 1'b1;
        else if (cnt_q >= 32'(POLL_GAP - 1)) begin
          state_d = S_POLL_AR; arvalid_d = 1'b1; rready_d = 1'b1; araddr_d = SR_ADDR;
        end
      end
      S_WR: begin
        // First cycle in WR latches the table row so it may change during the burst
        if (!issued_q) begin
          if (lost) restart = 1'b1;
          else begin
            addr_d = cfg_addr; data_d = cfg_data; issued_d = 1'b1;
            awvalid_d = 1'b1; wvalid_d = 1'b1; aw_ok_d = 1'b0; w_ok_d = 1'b0;
          end
        end else begin
          if (aw_acc) begin awvalid_d = 1'b0; aw_ok_d = 1'b1; end
          if (w_acc) begin wvalid_d = 1'b0; w_ok_d = 1'b1; end
          if ((aw_ok_q | aw_acc) & (w_ok_q | w_acc)) begin
            state_d = S_WR_B; bready_d = 1'b1;
          end else if (tmo) tmo_hit = 1'b1;
        end
      end
      S_WR_B: begin
        if (mmr.bvalid) begin
          bready_d = 1'b0;
          if (mmr.bresp != 2'b00) err_hit = 1'b1;
`ifdef SCC_CFG_VERIFY_EN
          else if (addr_q[7:0] == 8'h08 || addr_q[7:0] == 8'h0C) entry_ok = 1'b1;
          else begin
            state_d = S_VFY_AR; arvalid_d = 1'b1; rready_d = 1'b1; araddr_d = addr_q;
          end
`else
          else entry_ok = 1'b1;
`endif
        end else if (tmo) tmo_hit = 1'b1;
      end
`ifdef SCC_CFG_VERIFY_EN
      S_VFY_AR: begin
        if (mmr.arready) begin
          arvalid_d = 1'b0; state_d = S_VFY_R;
        end else if (tmo) tmo_hit = 1'b1;
      end
      S_VFY_R: begin
        if (mmr.rvalid) begin
          rready_d = 1'b0;
          if (mmr.rresp != 2'b00 || mmr.rdata != data_q) err_hit = 1'b1;
          else entry_ok = 1'b1;
        end else if (tmo) tmo_hit = 1'b1;
      end
`endif
      S_DONE: begin
        done_d = 1'b1; busy_d = 1'b0; state_d = S_IDLE;
      end
      S_ERR: begin
        error_d = 1'b1; err_idx_d = idx_q; busy_d = 1'b0;
        rready_d = 1'b0; bready_d = 1'b0; state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (entry_ok) begin
      if (lost) restart = 1'b1;
      else if (idx_q == 8'(N_ENTRIES - 1)) state_d = S_DONE;
      else begin
        idx_d = idx_q + 8'd1; state_d = S_WR; issued_d = 1'b0;
      end
    end
    // A timeout caused by lock loss is a re-run, not a configuration failure
    if (tmo_hit) begin
      if (lost) restart = 1'b1;
      else err_hit = 1'b1;
    end
    if (err_hit) begin
      state_d = S_ERR; arvalid_d = 1'b0; awvalid_d = 1'b0; wvalid_d = 1'b0;
      rready_d = 1'b1; bready_d = 1'b1;
    end else if (restart) begin
      state_d = S_WAIT_LOCK; idx_d = 8'd0; arvalid_d = 1'b0; awvalid_d = 1'b0;
      wvalid_d = 1'b0; rready_d = 1'b0; bready_d = 1'b0;
    end

    cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;  cnt_q <= '0;     idx_q <= '0;     err_idx_q <= '0;
      addr_q <= '0;       data_q <= '0;    araddr_q <= '0;
      arvalid_q <= 1'b0;  rready_q <= 1'b0; awvalid_q <= 1'b0; wvalid_q <= 1'b0;
      bready_q <= 1'b0;   aw_ok_q <= 1'b0; w_ok_q <= 1'b0;  issued_q <= 1'b0;
      lost_q <= 1'b0;     busy_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;  idx_q <= idx_d;  err_idx_q <= err_idx_d;
      addr_q <= addr_d;   data_q <= data_d; araddr_q <= araddr_d;
      arvalid_q <= arvalid_d; rready_q <= rready_d; awvalid_q <= awvalid_d;
      wvalid_q <= wvalid_d; bready_q <= bready_d; aw_ok_q <= aw_ok_d;
      w_ok_q <= w_ok_d;   issued_q <= issued_d; lost_q <= lost_d;
      busy_q <= busy_d;   done_q <= done_d; error_q <= error_d;
    end
  end

  assign cfg_idx     = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign err_idx     = err_idx_q;
  assign mmr.awvalid = awvalid_q;
  assign mmr.awaddr  = addr_q;
  assign mmr.wvalid  = wvalid_q;
  assign mmr.wdata   = data_q;
  assign mmr.wstrb   = 4'hF;
  assign mmr.bready  = bready_q;
  assign mmr.arvalid = arvalid_q;
  assign mmr.araddr  = araddr_q;
  assign mmr.rready  = rready_q;
endmodule
